// File: rtl/jtag_debug_tap_mux.sv
// JTAG TAP routing host JTAG to one of NUM_TGTS debug targets by IR code,
// with IDCODE/BYPASS and a JTAG-writable per-target reset mask.
module jtag_debug_tap_mux #(
  parameter int                  NUM_TGTS              = 4,
  parameter int                  IR_WIDTH              = 8,
  parameter logic [IR_WIDTH-1:0] IR_CODE_BASE          = 'h55,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR          = 'h01,
  parameter logic [IR_WIDTH-1:0] RSTMASK_INSTR         = 'h10,
  parameter logic [31:0]         IDCODE_VALUE          = 32'h1000_03CF,
  parameter logic [NUM_TGTS-1:0] TGT_RESET_ACTIVE_HIGH = {NUM_TGTS{1'b1}}
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_OE,
  input  logic [NUM_TGTS-1:0] TGT_TDO,
  output logic [NUM_TGTS-1:0] TGT_TMS,
  output logic [NUM_TGTS-1:0] TGT_TDI,
  output logic [NUM_TGTS-1:0] TGT_TCK_EN,
  output logic [NUM_TGTS-1:0] TGT_RESET,
  output logic [3:0]          TAP_STATE,
  output logic                SEL_VALID
);

  typedef enum logic [3:0] {
    TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3,
    SH_DR = 4'd4, EX1_DR = 4'd5, PAU_DR = 4'd6, EX2_DR = 4'd7,
    UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_t;

  tap_state_t state_reg, state_next;

  logic [IR_WIDTH-1:0] ir_shift_reg, ir_active_reg;
  logic [31:0]         idcode_shift_reg;
  logic [NUM_TGTS-1:0] mask_shift_reg, mask_reg;
  logic                bypass_reg;
  logic                tdo_reg, tdo_oe_reg;

  logic                is_tlr, ir_phase;
  logic [IR_WIDTH:0]   ir_off;
  logic [3:0]          sel_idx;
  logic [NUM_TGTS-1:0] tgt_sel;
  logic                is_idcode, is_rstmask, dr_lsb, tgt_tdo_sel;

  always_ff @(posedge TCK) begin
    if (TRST) state_reg <= TLR;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TLR:     state_next = TMS ? TLR    : RTI;
      RTI:     state_next = TMS ? SEL_DR : RTI;
      SEL_DR:  state_next = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_next = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_next = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_next = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_next = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_next = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_next = TMS ? SEL_DR : RTI;
      SEL_IR:  state_next = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_next = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_next = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_next = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_next = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_next = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_next = TMS ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  always_comb begin
    TAP_STATE = state_reg;
    is_tlr    = (state_reg == TLR);
    ir_phase  = (state_reg >= SEL_IR);
  end

  // Out-of-range codes wrap negative (top bit set) or exceed NUM_TGTS.
  assign ir_off     = {1'b0, ir_active_reg} - {1'b0, IR_CODE_BASE};
  assign sel_idx    = ir_off[3:0];
  assign SEL_VALID  = !ir_off[IR_WIDTH] && (ir_off < (IR_WIDTH+1)'(NUM_TGTS));
  assign is_idcode  = !SEL_VALID && (ir_active_reg == IDCODE_INSTR);
  assign is_rstmask = !SEL_VALID && (ir_active_reg == RSTMASK_INSTR);
  assign dr_lsb     = is_idcode  ? idcode_shift_reg[0] :
                      is_rstmask ? mask_shift_reg[0]   : bypass_reg;
  assign tgt_tdo_sel = |(TGT_TDO & tgt_sel);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TGTS; gi++) begin : g_tgt
      assign tgt_sel[gi]    = SEL_VALID && (sel_idx == 4'(gi));
      assign TGT_TMS[gi]    = tgt_sel[gi] ? TMS : 1'b1;
      assign TGT_TDI[gi]    = tgt_sel[gi] ? TDI : 1'b0;
      assign TGT_TCK_EN[gi] = tgt_sel[gi] && !ir_phase;
      assign TGT_RESET[gi]  = (TRST | is_tlr | mask_reg[gi]) ~^ TGT_RESET_ACTIVE_HIGH[gi];
    end
  endgenerate

  // Clearing on the edge that enters TLR keeps the whole TLR dwell in reset.
  always_ff @(posedge TCK) begin
    if (TRST || state_next == TLR) begin
      ir_shift_reg     <= IR_WIDTH'(1);
      ir_active_reg    <= IDCODE_INSTR;
      idcode_shift_reg <= '0;
      mask_shift_reg   <= '0;
      mask_reg         <= '0;
      bypass_reg       <= 1'b0;
      tdo_reg          <= 1'b0;
      tdo_oe_reg       <= 1'b0;
    end else begin
      case (state_reg)
        CAP_IR: ir_shift_reg <= IR_WIDTH'(1);
        SH_IR:  ir_shift_reg <= {TDI, ir_shift_reg[IR_WIDTH-1:1]};
        UPD_IR: ir_active_reg <= ir_shift_reg;
        CAP_DR: begin
          idcode_shift_reg <= IDCODE_VALUE;
          mask_shift_reg   <= mask_reg;
          bypass_reg       <= 1'b0;
        end
        SH_DR: begin
          idcode_shift_reg <= {TDI, idcode_shift_reg[31:1]};
          mask_shift_reg   <= (mask_shift_reg >> 1) | (NUM_TGTS'(TDI) << (NUM_TGTS-1));
          bypass_reg       <= TDI;
        end
        UPD_DR: if (is_rstmask) mask_reg <= mask_shift_reg;
        default: ;
      endcase
      tdo_oe_reg <= (state_reg == SH_IR) || (state_reg == SH_DR);
      if (state_reg == SH_IR)      tdo_reg <= ir_shift_reg[0];
      else if (state_reg == SH_DR) tdo_reg <= SEL_VALID ? tgt_tdo_sel : dr_lsb;
    end
  end

  assign TDO    = tdo_reg;
  assign TDO_OE = tdo_oe_reg;

endmodule

// File: tb/tb_jtag_debug_tap_mux.sv
// Directed bench for jtag_debug_tap_mux: 4 targets, mixed reset polarity 4'b0111.
module tb_jtag_debug_tap_mux;

  localparam logic [3:0]  AH     = 4'b0111;
  localparam logic [31:0] IDCODE = 32'h1000_03CF;

  logic       TCK = 1'b0;
  logic       TRST, TMS, TDI;
  logic       TDO, TDO_OE, SEL_VALID;
  logic [3:0] TGT_TDO, TGT_TMS, TGT_TDI, TGT_TCK_EN, TGT_RESET, TAP_STATE;

  int checks = 0;
  int failures = 0;
  logic [31:0] d;

  jtag_debug_tap_mux #(.NUM_TGTS(4), .TGT_RESET_ACTIVE_HIGH(AH)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_OE(TDO_OE),
    .TGT_TDO(TGT_TDO), .TGT_TMS(TGT_TMS), .TGT_TDI(TGT_TDI),
    .TGT_TCK_EN(TGT_TCK_EN), .TGT_RESET(TGT_RESET),
    .TAP_STATE(TAP_STATE), .SEL_VALID(SEL_VALID)
  );

  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic tms, input logic tdi);
    @(negedge TCK);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // From RTI: load code into the IR and return to RTI.
  task automatic scan_ir(input logic [7:0] code);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("ir_shift_st", TAP_STATE, 11);
    for (int k = 0; k < 8; k++) begin
      step(k == 7, code[k]);
      chk("ir_tdo", TDO, (k == 0) ? 1 : 0);
      chk("ir_oe", TDO_OE, 1);
    end
    step(1, 0);
    step(0, 0);
  endtask

  // From RTI: shift len bits of din; target 2 drives tpat, the others its complement.
  task automatic scan_dr(input logic [31:0] din, input int len, input logic [31:0] tpat,
                         output logic [31:0] dout);
    dout = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int k = 0; k < len; k++) begin
      TGT_TDO = {~tpat[k], tpat[k], ~tpat[k], ~tpat[k]};
      step(k == len - 1, din[k]);
      dout[k] = TDO;
      chk("dr_oe", TDO_OE, 1);
    end
    step(1, 0);
    chk("dr_oe_off", TDO_OE, 0);
    step(0, 0);
  endtask

  initial begin
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; TGT_TDO = '0;
    @(posedge TCK); #1;
    chk("rst_state", TAP_STATE, 0);
    chk("rst_tgt_reset", TGT_RESET, 4'b0111);
    chk("rst_oe", TDO_OE, 0);
    chk("rst_tdo", TDO, 0);
    chk("rst_sel", SEL_VALID, 0);
    chk("rst_tck_en", TGT_TCK_EN, 0);
    TRST = 1'b0;
    step(0, 0);
    chk("rti_state", TAP_STATE, 1);
    chk("rti_tgt_reset", TGT_RESET, 4'b1000);
    chk("rti_tgt_tms", TGT_TMS, 4'b1111);
    chk("rti_oe", TDO_OE, 0);

    scan_dr(32'h0, 32, 32'h0, d);
    chk("idcode", d, IDCODE);

    scan_ir(8'h57);
    chk("t2_sel", SEL_VALID, 1);
    chk("t2_tck_en", TGT_TCK_EN, 4'b0100);
    chk("t2_tms", TGT_TMS, 4'b1011);
    chk("t2_tdi0", TGT_TDI, 4'b0000);
    TDI = 1'b1; #1;
    chk("t2_tdi1", TGT_TDI, 4'b0100);
    TDI = 1'b0;
    scan_dr(32'h0, 8, 32'hC5, d);
    chk("t2_tdo_mirror", d[7:0], 8'hC5);

    step(1, 0);
    chk("seldr_tck_en", TGT_TCK_EN, 4'b0100);
    step(1, 0);
    chk("selir_state", TAP_STATE, 9);
    chk("selir_tck_en", TGT_TCK_EN, 0);
    step(0, 0);
    step(1, 0);
    chk("ex1ir_tck_en", TGT_TCK_EN, 0);
    step(1, 0);
    chk("updir_state", TAP_STATE, 15);
    chk("updir_sel_hold", SEL_VALID, 1);
    step(0, 0);
    chk("after_upd_sel", SEL_VALID, 0);
    chk("after_upd_en", TGT_TCK_EN, 0);

    scan_ir(8'h10);
    scan_dr(32'hA, 4, 32'h0, d);
    chk("mask_initial", d[3:0], 4'b0000);
    chk("mask_reset_out", TGT_RESET, 4'b0010);
    scan_dr(32'hA, 4, 32'h0, d);
    chk("mask_readback", d[3:0], 4'b1010);

    scan_ir(8'h5A);
    chk("oor_sel", SEL_VALID, 0);
    chk("oor_tck_en", TGT_TCK_EN, 0);
    scan_dr(32'hB, 4, 32'hF, d);
    chk("bypass_delay", d[3:0], 4'b0110);

    scan_ir(8'h57);
    chk("resel_sel", SEL_VALID, 1);
    chk("resel_mask", TGT_RESET, 4'b0010);

    step(1, 0); step(0, 0);
    TGT_TDO = 4'b0100;
    step(0, 1);
    chk("mid_state", TAP_STATE, 4);
    step(1, 0);
    chk("mid_tdo", TDO, 1);
    for (int k = 0; k < 4; k++) step(1, 0);
    chk("tlr_state", TAP_STATE, 0);
    chk("tlr_tgt_reset", TGT_RESET, 4'b0111);
    chk("tlr_sel", SEL_VALID, 0);
    chk("tlr_tck_en", TGT_TCK_EN, 0);
    chk("tlr_tdo", TDO, 0);
    chk("tlr_oe", TDO_OE, 0);
    step(0, 0);
    chk("post_tlr_reset", TGT_RESET, 4'b1000);
    chk("post_tlr_tms", TGT_TMS, 4'b1111);
    scan_dr(32'h0, 32, 32'h0, d);
    chk("post_tlr_idcode", d, IDCODE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
